ysyx_22041211_ifu: RTL and testbench

Instruction fetch unit for the ysyx_22041211 multi-cycle RV32 core. It holds the architectural PC and issues one word fetch per instruction over a valid/ready request plus valid response instruction-memory port. It buffers the returned word and presents `inst_o`/`pc_o` to the decoder under a valid/ready handshake. On each handshake it selects the next PC from the decoder's jump outputs, the execute-stage branch result, or PC+4, and it accepts an asynchronous-to-flow flush redirect in any state.

---
 rtl/ysyx_22041211_ifu.sv | 161 ++++++++++++++++
 tb/tb_ysyx_22041211_ifu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit for the ysyx_22041211 multi-cycle RV32 core.
// Fetches one word per instruction, buffers it, and hands it to the decoder under valid/ready.
module ysyx_22041211_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,

    // Instruction memory port.
    // Request: a transfer happens on a cycle where imem_req_valid_o and imem_req_ready_i are both 1;
    // valid and address stay stable until then. Response: imem_resp_valid_i is a one-cycle strobe,
    // at most one per accepted request, and has no ready (the IFU always takes it in WAIT).
    // Decoder port: a handshake happens on a cycle where inst_valid_o and id_ready_i are both 1;
    // inst_o/pc_o stay stable until then.
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,

    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o,
    input  logic        id_ready_i,

    input  logic        jmp_flag_i,
    input  logic [31:0] jmp_target_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,

    output logic [1:0]  dbg_state_o,
    output logic        dbg_discard_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        discard_q;
    logic        discard_d;
    logic        latch_en;
    logic        req_valid_q;
    logic        inst_valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic [31:0] seq_pc;
    logic [31:0] redirect_pc;

    assign seq_pc = pc_q + 32'd4;

    // Branch resolution outranks the decoder's jump; both are word-aligned.
    always_comb begin
        redirect_pc = seq_pc;
        if (branch_flag_i) begin
            redirect_pc = branch_target_i & 32'hFFFF_FFFC;
        end else if (jmp_flag_i) begin
            redirect_pc = jmp_target_i & 32'hFFFF_FFFC;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        latch_en  = 1'b0;
        if (flush_i) begin
            pc_d = flush_pc_i & 32'hFFFF_FFFC;
            case (state_q)
                S_IDLE, S_HOLD: begin
                    state_d = S_REQ;
                end
                S_REQ: begin
                    // A request already handed to memory will still answer; drop that answer.
                    if (imem_req_ready_i) begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid_i) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_REQ;
                end
                S_REQ: begin
                    if (imem_req_ready_i) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid_i) begin
                        discard_d = 1'b0;
                        if (discard_q) begin
                            state_d = S_REQ;
                        end else begin
                            state_d  = S_HOLD;
                            latch_en = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (id_ready_i) begin
                        state_d = S_REQ;
                        pc_d    = redirect_pc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Valid outputs are registered copies of the next state so they never see an input combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            req_valid_q  <= (state_d == S_REQ);
            inst_valid_q <= (state_d == S_HOLD);
            if (latch_en) begin
                inst_q    <= imem_resp_data_i;
                inst_pc_q <= pc_q;
            end
        end
    end

    assign imem_req_valid_o = req_valid_q;
    assign imem_req_addr_o  = pc_q;
    assign inst_valid_o     = inst_valid_q;
    assign inst_o           = inst_q;
    assign pc_o             = inst_pc_q;
    assign dbg_state_o      = state_q;
    assign dbg_discard_o    = discard_q;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Bench for ysyx_22041211_ifu: cycle-by-cycle directed vector table plus a free-running fetch sequence.
module tb_ysyx_22041211_ifu;

    localparam logic [6:0] C_RST = 7'b1000000;
    localparam logic [6:0] C_RDY = 7'b0100000;
    localparam logic [6:0] C_RV  = 7'b0010000;
    localparam logic [6:0] C_ID  = 7'b0001000;
    localparam logic [6:0] C_J   = 7'b0000100;
    localparam logic [6:0] C_B   = 7'b0000010;
    localparam logic [6:0] C_F   = 7'b0000001;

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] rdata;
        logic [31:0] tgt_a;
        logic [31:0] tgt_b;
        logic [1:0]  st;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] inst;
        logic [31:0] pc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_valid_o;
    logic        id_ready_i;
    logic        jmp_flag_i;
    logic [31:0] jmp_target_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [1:0]  dbg_state_o;
    logic        dbg_discard_o;

    int vectors;
    int miscompares;
    vec_t vecs[$];
    logic [31:0] exp_q[$];

    ysyx_22041211_ifu dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_resp_valid_i(imem_resp_valid_i),
        .imem_resp_data_i (imem_resp_data_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .inst_valid_o     (inst_valid_o),
        .id_ready_i       (id_ready_i),
        .jmp_flag_i       (jmp_flag_i),
        .jmp_target_i     (jmp_target_i),
        .branch_flag_i    (branch_flag_i),
        .branch_target_i  (branch_target_i),
        .flush_i          (flush_i),
        .flush_pc_i       (flush_pc_i),
        .dbg_state_o      (dbg_state_o),
        .dbg_discard_o    (dbg_discard_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic row(input logic [6:0] ctl, input logic [31:0] rdata, input logic [31:0] tgt_a,
                       input logic [31:0] tgt_b, input logic [1:0] st, input logic rv,
                       input logic [31:0] addr, input logic iv, input logic [31:0] inst,
                       input logic [31:0] pc);
        vec_t v;
        v.ctl = ctl; v.rdata = rdata; v.tgt_a = tgt_a; v.tgt_b = tgt_b;
        v.st = st; v.rv = rv; v.addr = addr; v.iv = iv; v.inst = inst; v.pc = pc;
        vecs.push_back(v);
    endtask

    // Driver: jmp target comes from tgt_a, branch target and flush pc from tgt_b.
    task automatic drive(input vec_t v);
        rst               = v.ctl[6];
        imem_req_ready_i  = v.ctl[5];
        imem_resp_valid_i = v.ctl[4];
        id_ready_i        = v.ctl[3];
        jmp_flag_i        = v.ctl[2];
        branch_flag_i     = v.ctl[1];
        flush_i           = v.ctl[0];
        imem_resp_data_i  = v.rdata;
        jmp_target_i      = v.tgt_a;
        branch_target_i   = v.tgt_b;
        flush_pc_i        = v.tgt_b;
    endtask

    task automatic check_row(input int idx, input vec_t v);
        vectors++;
        if (dbg_state_o !== v.st || imem_req_valid_o !== v.rv || imem_req_addr_o !== v.addr ||
            inst_valid_o !== v.iv || inst_o !== v.inst || pc_o !== v.pc) begin
            miscompares++;
            $display("FAIL row%0d: got st=%0d rv=%0b addr=%h iv=%0b inst=%h pc=%h, want st=%0d rv=%0b addr=%h iv=%0b inst=%h pc=%h",
                     idx, dbg_state_o, imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, pc_o,
                     v.st, v.rv, v.addr, v.iv, v.inst, v.pc);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    initial begin
        vec_t idle;
        int req_cyc[$];
        int iv_count;
        logic acc_prev;

        vectors = 0;
        miscompares = 0;
        idle = '{ctl: 7'd0, rdata: 32'd0, tgt_a: 32'd0, tgt_b: 32'd0, st: 2'd0, rv: 1'b0,
                 addr: 32'd0, iv: 1'b0, inst: 32'd0, pc: 32'd0};
        drive(idle);
        rst = 1'b1;

        // Straight-line fetch, reset state first.
        row(0,     0,            0, 0, 0, 0, 32'h8000_0000, 0, 0, 0);
        row(C_RDY, 0,            0, 0, 1, 1, 32'h8000_0000, 0, 0, 0);
        row(C_RV,  32'h13,       0, 0, 2, 0, 32'h8000_0000, 0, 0, 0);
        row(C_ID,  0,            0, 0, 3, 0, 32'h8000_0000, 1, 32'h13, 32'h8000_0000);
        row(C_RDY, 0,            0, 0, 1, 1, 32'h8000_0004, 0, 32'h13, 32'h8000_0000);
        row(C_RV,  32'h13,       0, 0, 2, 0, 32'h8000_0004, 0, 32'h13, 32'h8000_0000);
        row(C_ID,  0,            0, 0, 3, 0, 32'h8000_0004, 1, 32'h13, 32'h8000_0004);
        row(C_RDY, 0,            0, 0, 1, 1, 32'h8000_0008, 0, 32'h13, 32'h8000_0004);
        row(C_RV,  32'h0010_0093, 0, 0, 2, 0, 32'h8000_0008, 0, 32'h13, 32'h8000_0004);
        row(C_ID,  0,            0, 0, 3, 0, 32'h8000_0008, 1, 32'h0010_0093, 32'h8000_0008);
        // Memory backpressure for 5 cycles.
        for (int i = 0; i < 5; i++)
            row(0, 0, 0, 0, 1, 1, 32'h8000_000C, 0, 32'h0010_0093, 32'h8000_0008);
        row(C_RDY, 0,            0, 0, 1, 1, 32'h8000_000C, 0, 32'h0010_0093, 32'h8000_0008);
        row(C_RV,  32'h0020_0113, 0, 0, 2, 0, 32'h8000_000C, 0, 32'h0010_0093, 32'h8000_0008);
        // Decoder stall: stray response and redirects outside the handshake are ignored.
        row(0,     0,            0, 0, 3, 0, 32'h8000_000C, 1, 32'h0020_0113, 32'h8000_000C);
        row(C_RV,  32'hBAD0_BAD0, 0, 0, 3, 0, 32'h8000_000C, 1, 32'h0020_0113, 32'h8000_000C);
        row(C_B,   0, 0, 32'h1234_5678, 3, 0, 32'h8000_000C, 1, 32'h0020_0113, 32'h8000_000C);
        row(C_J,   0, 32'h40, 0,        3, 0, 32'h8000_000C, 1, 32'h0020_0113, 32'h8000_000C);
        // Branch beats jump.
        row(C_ID | C_J | C_B, 0, 32'h8000_0200, 32'h8000_0100, 3, 0, 32'h8000_000C, 1, 32'h0020_0113, 32'h8000_000C);
        row(C_RDY, 0,            0, 0, 1, 1, 32'h8000_0100, 0, 32'h0020_0113, 32'h8000_000C);
        row(C_RV,  32'h6F,       0, 0, 2, 0, 32'h8000_0100, 0, 32'h0020_0113, 32'h8000_000C);
        // Misaligned jump target is word-aligned.
        row(C_ID | C_J, 0, 32'h8000_0203, 0, 3, 0, 32'h8000_0100, 1, 32'h6F, 32'h8000_0100);
        row(C_RDY, 0,            0, 0, 1, 1, 32'h8000_0200, 0, 32'h6F, 32'h8000_0100);
        // Flush in WAIT, response 3 cycles later is dropped.
        row(C_F,   0, 0, 32'h8000_1000, 2, 0, 32'h8000_0200, 0, 32'h6F, 32'h8000_0100);
        row(0,     0,            0, 0, 2, 0, 32'h8000_1000, 0, 32'h6F, 32'h8000_0100);
        row(0,     0,            0, 0, 2, 0, 32'h8000_1000, 0, 32'h6F, 32'h8000_0100);
        row(C_RV,  32'hDEAD_BEEF, 0, 0, 2, 0, 32'h8000_1000, 0, 32'h6F, 32'h8000_0100);
        row(C_RDY, 0,            0, 0, 1, 1, 32'h8000_1000, 0, 32'h6F, 32'h8000_0100);
        row(C_RV,  32'h513,      0, 0, 2, 0, 32'h8000_1000, 0, 32'h6F, 32'h8000_0100);
        // Flush on the handshake cycle overrides the jump.
        row(C_ID | C_J | C_F, 0, 32'h8000_2000, 32'h8000_3003, 3, 0, 32'h8000_1000, 1, 32'h513, 32'h8000_1000);
        row(C_RDY, 0,            0, 0, 1, 1, 32'h8000_3000, 0, 32'h513, 32'h8000_1000);
        row(C_RV,  32'h593,      0, 0, 2, 0, 32'h8000_3000, 0, 32'h513, 32'h8000_1000);
        // Branch to top of address space, then sequential wrap.
        row(C_ID | C_B, 0, 0, 32'hFFFF_FFFE, 3, 0, 32'h8000_3000, 1, 32'h593, 32'h8000_3000);
        row(C_RDY, 0,            0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h593, 32'h8000_3000);
        row(C_RV,  32'h613,      0, 0, 2, 0, 32'hFFFF_FFFC, 0, 32'h593, 32'h8000_3000);
        row(C_ID,  0,            0, 0, 3, 0, 32'hFFFF_FFFC, 1, 32'h613, 32'hFFFF_FFFC);
        row(C_RDY, 0,            0, 0, 1, 1, 32'h0000_0000, 0, 32'h613, 32'hFFFF_FFFC);
        // Reset mid-WAIT; later responses in IDLE and REQ are ignored.
        row(C_RST, 0,            0, 0, 2, 0, 32'h0000_0000, 0, 32'h613, 32'hFFFF_FFFC);
        row(C_RV,  32'hCAFE_F00D, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0);
        row(C_RV,  32'h1111_1111, 0, 0, 1, 1, 32'h8000_0000, 0, 0, 0);
        // Flush in the same cycle the request is accepted.
        row(C_RDY | C_F, 0, 0, 32'h8000_4000, 1, 1, 32'h8000_0000, 0, 0, 0);
        row(C_RV,  32'h2222_2222, 0, 0, 2, 0, 32'h8000_4000, 0, 0, 0);
        // Flush in REQ without acceptance.
        row(C_F,   0, 0, 32'h8000_5000, 1, 1, 32'h8000_4000, 0, 0, 0);
        row(C_RDY, 0,            0, 0, 1, 1, 32'h8000_5000, 0, 0, 0);
        // Flush coinciding with the response.
        row(C_RV | C_F, 32'h4444_4444, 0, 32'h8000_6000, 2, 0, 32'h8000_5000, 0, 0, 0);
        row(C_RDY, 0,            0, 0, 1, 1, 32'h8000_6000, 0, 0, 0);
        row(C_RV,  32'h3333_3333, 0, 0, 2, 0, 32'h8000_6000, 0, 0, 0);
        // Flush in HOLD without handshake.
        row(C_F,   0, 0, 32'h8000_7000, 3, 0, 32'h8000_6000, 1, 32'h3333_3333, 32'h8000_6000);
        row(C_RST, 0,            0, 0, 1, 1, 32'h8000_7000, 0, 32'h3333_3333, 32'h8000_6000);
        // Flush in IDLE.
        row(C_F,   0, 0, 32'h8000_8000, 0, 0, 32'h8000_0000, 0, 0, 0);
        row(0,     0,            0, 0, 1, 1, 32'h8000_8000, 0, 0, 0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_row(i, vecs[i]);
        end

        // Free-running fetch after reset: requests on cycles 1, 4, 7, each pc_o matched in order.
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        @(negedge clk);
        acc_prev = 1'b0;
        iv_count = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc != 0) @(negedge clk);
            rst               = 1'b0;
            imem_req_ready_i  = 1'b1;
            imem_resp_valid_i = acc_prev;
            imem_resp_data_i  = 32'h13;
            id_ready_i        = 1'b1;
            #1;
            acc_prev = imem_req_valid_o && imem_req_ready_i;
            if (acc_prev) begin
                req_cyc.push_back(cyc);
                exp_q.push_back(32'h8000_0000 + 32'(4 * (req_cyc.size() - 1)));
            end
            if (inst_valid_o) begin
                iv_count++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL seq_pc: inst_valid with no outstanding request at cycle %0d", cyc);
                end else begin
                    check_val("seq_pc", pc_o, exp_q.pop_front());
                    check_val("seq_inst", inst_o, 32'h13);
                end
            end
        end
        check_val("seq_req_count", 32'(req_cyc.size()), 32'd4);
        check_val("seq_iv_count", 32'(iv_count), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < req_cyc.size())
                check_val("seq_req_cycle", 32'(req_cyc[k]), 32'(1 + 3 * k));
            else begin
                vectors++;
                miscompares++;
                $display("FAIL seq_req_cycle: request %0d missing, want cycle %0d", k, 1 + 3 * k);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
